dac_ltc2624_ctrl: RTL and testbench

System-clock master that sequences the LTC2624 quad DAC on the starter board.
- After reset it runs the DAC_CLR init pulse, then waits for requests.
- Each accepted request becomes one 32-bit SPI frame: immediate write-and-update command to one channel or to all channels.
- The block captures the DAC's shifted-out echo of the previous frame and flags any mismatch.
- It sits between application logic (valid/ready request port) and the SPI_SCK / DAC_CS / DAC_CLR / SPI_MOSI / DAC_OUT board pins.

---
 rtl/dac_ltc2624_pkg.sv | 18 +
 rtl/spi_shift32.sv | 59 +++++
 rtl/dac_ltc2624_ctrl.sv | 108 ++++++++++
 tb/tb_dac_ltc2624_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dac_ltc2624_pkg.sv
// dac_ltc2624_pkg: shared states, constants and frame helpers for the LTC2624 controller
package dac_ltc2624_pkg;
  typedef enum logic [2:0] {S_BOOT, S_CLR, S_INITW, S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;
  typedef logic [15:0] cnt_t;
  localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
  localparam logic [3:0] ADDR_A = 4'h0;
  localparam logic [3:0] ADDR_B = 4'h1;
  localparam logic [3:0] ADDR_C = 4'h2;
  localparam logic [3:0] ADDR_D = 4'h3;
  localparam logic [3:0] ADDR_ALL = 4'hF;
  function automatic logic addr_legal(input logic [3:0] addr);
    return addr <= ADDR_D || addr == ADDR_ALL;
  endfunction
  function automatic logic [31:0] make_frame(input logic [3:0] addr, input logic [11:0] data,
                                             input logic [3:0] cmd = CMD_WRITE_UPDATE);
    return {8'h00, cmd, addr, data, 4'h0};
  endfunction
endpackage

// File: rtl/spi_shift32.sv
// spi_shift32: SCK divider, 32-bit MSB-first MOSI shifter and echo capture
module spi_shift32 #(
  parameter int DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] frame,
  input  logic        din,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] echo,
  output logic        last_fall
);
  logic busy;
  logic [6:0] h;
  logic [6:0] h_nx;
  logic [7:0] cnt;
  logic [31:0] sh;
  logic tick;
  // h walks the half-periods: 0 setup, odd = low phase, even = high phase, 64 = last high
  assign tick = cnt == 8'(DIV - 1);
  assign h_nx = h + 7'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      busy <= 1'b0;
      h <= '0;
      cnt <= '0;
      sh <= '0;
      sck <= 1'b0;
      mosi <= 1'b0;
      echo <= '0;
      last_fall <= 1'b0;
    end else begin
      last_fall <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        h <= '0;
        cnt <= '0;
        mosi <= frame[31];
        sh <= {frame[30:0], 1'b0};
      end else if (busy) begin
        cnt <= tick ? 8'd0 : cnt + 8'd1;
        if (cnt == 8'd0 && h[0] && h >= 7'd3) begin
          mosi <= sh[31];
          sh <= sh << 1;
        end
        if (tick) begin
          h <= h_nx;
          sck <= !h_nx[0];
          if (!h[0] && h != 7'd0) echo <= {echo[30:0], din};
          if (h == 7'd64) begin
            busy <= 1'b0;
            last_fall <= 1'b1;
          end
        end
      end
    end
endmodule

// File: rtl/dac_ltc2624_ctrl.sv
// dac_ltc2624_ctrl: LTC2624 init, request handshake and frame sequencing with echo check
module dac_ltc2624_ctrl
  import dac_ltc2624_pkg::*;
#(
  parameter int DIV = 2,
  parameter int CLR_CYCLES = 4,
  parameter int INIT_WAIT = 8,
  parameter logic [3:0] CMD = CMD_WRITE_UPDATE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_addr,
  input  logic [11:0] req_data,
  input  logic        reinit,
  output logic        done,
  output logic        addr_err,
  output logic [31:0] echo_data,
  output logic        echo_err,
  output logic        spi_sck,
  output logic        spi_mosi,
  output logic        dac_cs,
  output logic        dac_clr,
  input  logic        dac_out
);
  state_t state;
  cnt_t cnt;
  logic [31:0] frame;
  logic [31:0] frame_q;
  logic [31:0] last_sent;
  logic [31:0] echo;
  logic start;
  logic last_fall;
  assign frame = make_frame(req_addr, req_data, CMD);
  assign start = state == S_IDLE && req_valid && !reinit && addr_legal(req_addr);
  spi_shift32 #(.DIV(DIV)) u_shift (
    .clk(clk), .rst_n(rst_n), .start(start), .frame(frame), .din(dac_out),
    .sck(spi_sck), .mosi(spi_mosi), .echo(echo), .last_fall(last_fall)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_BOOT;
      cnt <= '0;
      dac_clr <= 1'b1;
      dac_cs <= 1'b1;
      req_ready <= 1'b0;
      done <= 1'b0;
      addr_err <= 1'b0;
      echo_data <= '0;
      echo_err <= 1'b0;
      last_sent <= '0;
      frame_q <= '0;
    end else begin
      done <= 1'b0;
      addr_err <= 1'b0;
      cnt <= cnt - cnt_t'(1);
      case (state)
        S_BOOT: begin
          state <= S_CLR;
          dac_clr <= 1'b0;
          cnt <= cnt_t'(CLR_CYCLES - 1);
        end
        S_CLR: if (cnt == '0) begin
          state <= S_INITW;
          dac_clr <= 1'b1;
          cnt <= cnt_t'(INIT_WAIT - 1);
        end
        S_INITW: if (cnt == '0) begin
          state <= S_IDLE;
          req_ready <= 1'b1;
        end
        S_IDLE: if (reinit) begin
          state <= S_CLR;
          dac_clr <= 1'b0;
          req_ready <= 1'b0;
          last_sent <= '0;
          cnt <= cnt_t'(CLR_CYCLES - 1);
        end else if (start) begin
          state <= S_SETUP;
          frame_q <= frame;
          dac_cs <= 1'b0;
          req_ready <= 1'b0;
          cnt <= cnt_t'(DIV - 1);
        end else if (req_valid) addr_err <= 1'b1;
        S_SETUP: if (cnt == '0) state <= S_SHIFT;
        // last_fall lags the 32nd fall by a cycle, so hold needs one count less
        S_SHIFT: if (last_fall) begin
          state <= S_HOLD;
          cnt <= cnt_t'(DIV - 2);
        end
        S_HOLD: if (cnt == '0) begin
          state <= S_GAP;
          dac_cs <= 1'b1;
          done <= 1'b1;
          echo_data <= echo;
          echo_err <= echo != last_sent;
          last_sent <= frame_q;
          cnt <= cnt_t'(DIV - 1);
        end
        S_GAP: if (cnt == '0) begin
          state <= S_IDLE;
          req_ready <= 1'b1;
        end
        default: state <= S_BOOT;
      endcase
    end
endmodule

// File: tb/tb_dac_ltc2624_ctrl.sv
// tb_dac_ltc2624_ctrl: scoreboard bench with a behavioural LTC2624 echo model
module tb_dac_ltc2624_ctrl;
  typedef struct {
    logic [31:0] frame;
    logic [31:0] echo;
    logic        err;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [3:0] req_addr = '0;
  logic [11:0] req_data = '0;
  logic reinit = 1'b0;
  logic done, addr_err, echo_err, spi_sck, spi_mosi, dac_cs, dac_clr, dac_out;
  logic [31:0] echo_data;
  int n_cmp = 0;
  int n_err = 0;
  exp_t q[$];
  logic [31:0] sent_prev = '0;
  logic [31:0] flip = '0;
  logic [31:0] sr = '0;
  logic [31:0] dac_prev = '0;
  logic [31:0] rx = '0;
  int falls = 0;
  int bad_fall = 0;
  int cs_low = 0;
  logic done_last = 1'b0;
  exp_t e;
  dac_ltc2624_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .reinit(reinit), .done(done),
    .addr_err(addr_err), .echo_data(echo_data), .echo_err(echo_err),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .dac_cs(dac_cs), .dac_clr(dac_clr),
    .dac_out(dac_out)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, got timeout want finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  // DAC model: returns the previous word on DAC_OUT, shifting after each SCK fall
  assign dac_out = sr[31];
  always @(negedge dac_cs) begin
    sr = dac_prev ^ flip;
    rx = '0;
    falls = 0;
    bad_fall = 0;
  end
  always @(posedge dac_cs) if (falls == 32) dac_prev = rx;
  always @(negedge dac_clr) dac_prev = '0;
  always @(posedge spi_sck) rx = {rx[30:0], spi_mosi};
  always @(negedge spi_sck) begin
    falls++;
    if (dac_cs && rst_n) bad_fall++;
    #1 sr = sr << 1;
  end
  always @(negedge clk) begin
    if (!rst_n) cs_low = 0;
    else begin
      if (!dac_cs) cs_low++;
      if (done_last) check("done_pulse", done, 0);
      if (done) begin
        check("sb_has_entry", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("mosi_frame", rx, e.frame);
          check("sck_falls", falls, 32);
          check("fall_cs_high", bad_fall, 0);
          check("cs_low_cycles", cs_low, 132);
          check("echo_data", echo_data, e.echo);
          check("echo_err", echo_err, e.err);
        end
        cs_low = 0;
      end
    end
    done_last = done;
  end
  task automatic measure_init();
    int lo = 0, hi = 0, csl = 0, n = 0;
    while (dac_clr && n < 50) begin
      @(negedge clk);
      n++;
      if (!dac_cs) csl++;
    end
    while (!dac_clr && n < 100) begin
      lo++;
      if (!dac_cs) csl++;
      @(negedge clk);
      n++;
    end
    while (dac_clr && !req_ready && n < 200) begin
      hi++;
      if (!dac_cs) csl++;
      @(negedge clk);
      n++;
    end
    check("clr_low_cycles", lo, 4);
    check("initw_cycles", hi, 8);
    check("init_ready", req_ready, 1);
    check("init_cs_low", csl, 0);
    sent_prev = '0;
  endtask
  task automatic send(input logic [3:0] a, input logic [11:0] d, input logic [31:0] fl);
    int n = 0;
    logic [31:0] f;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", req_ready, 1);
    f = {8'h00, 4'h3, a, d, 4'h0};
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    flip = fl;
    if (a < 4'd4 || a == 4'hF) begin
      q.push_back('{frame: f, echo: sent_prev ^ fl, err: fl != 0});
      sent_prev = f;
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_complete", req_ready, 1);
  endtask
  initial begin
    logic [3:0] bad [3];
    int csl, errs, n;
    bad = '{4'h4, 4'h9, 4'hE};
    repeat (3) @(negedge clk);
    check("rst_clr", dac_clr, 1);
    check("rst_cs", dac_cs, 1);
    check("rst_sck", spi_sck, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_ready", req_ready, 0);
    check("rst_done", done, 0);
    check("rst_addr_err", addr_err, 0);
    check("rst_echo", echo_data, 0);
    check("rst_echo_err", echo_err, 0);
    rst_n = 1'b1;
    measure_init();
    send(4'h1, 12'hABC, 0);
    wait_ready();
    send(4'hF, 12'h123, 0);
    wait_ready();
    send(4'h2, 12'hFFF, 32'h1);
    wait_ready();
    send(4'h0, 12'h000, 0);
    wait_ready();
    for (int i = 0; i < 3; i++) begin
      send(bad[i], 12'h5A5, 0);
      check("addr_err_pulse", addr_err, 1);
      check("addr_err_ready", req_ready, 1);
      csl = 0;
      errs = 0;
      repeat (6) begin
        @(negedge clk);
        if (!dac_cs) csl++;
        errs += int'(addr_err);
      end
      check("addr_err_no_cs", csl, 0);
      check("addr_err_once", errs, 0);
    end
    send(4'h3, 12'h555, 0);
    n = 0;
    while (falls < 10 && n < 300) begin
      @(negedge clk);
      n++;
    end
    while (!spi_sck && n < 320) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_sck_high", spi_sck, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cs", dac_cs, 1);
    check("midrst_sck", spi_sck, 0);
    check("midrst_clr", dac_clr, 1);
    check("midrst_ready", req_ready, 0);
    q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    measure_init();
    send(4'h3, 12'h777, 0);
    wait_ready();
    reinit = 1'b1;
    req_valid = 1'b1;
    req_addr = 4'h1;
    req_data = 12'h321;
    @(negedge clk);
    reinit = 1'b0;
    req_valid = 1'b0;
    check("reinit_ready", req_ready, 0);
    check("reinit_clr", dac_clr, 0);
    measure_init();
    send(4'h2, 12'h800, 0);
    wait_ready();
    repeat (4) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
